// File: rtl/spi_frame_loader_if.sv
// spi_frame_loader_if: frame-buffer write port between the SPI loader (master)
// and the back buffer / flipper (slave).
interface spi_frame_loader_if #(
    parameter int W  = 24,
    parameter int RW = 3,
    parameter int CW = 5
);
    logic [W-1:0]  wdata;
    logic [RW-1:0] wrow;
    logic [CW-1:0] wcol;
    logic          wen;
    logic          ready;
    logic          loaded;
    logic [7:0]    brightness;
    logic          err;
    modport master (output wdata, wrow, wcol, wen, loaded, brightness, err, input ready);
    modport slave  (input wdata, wrow, wcol, wen, loaded, brightness, err, output ready);
endinterface

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: decodes SPI command bytes and packs pixel bytes into frame-buffer writes.
// Defining SPI_BRIGHTNESS_EN enables the 0x20 brightness command; otherwise brightness stays 8'hFF.
module spi_frame_loader #(
    parameter int SEGMENTS = 1,
    parameter int CHANNELS = 3,
    parameter int ROWS     = 8,
    parameter int COLUMNS  = 32,
    parameter int BITWIDTH = 8,
    parameter int SS_SYNC  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic miso,
    spi_frame_loader_if.master fb
);
    localparam int N   = SEGMENTS * CHANNELS;
    localparam int W   = N * BITWIDTH;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int CLW = CW + 1;
    localparam int NW  = $clog2(N + 1);
`ifdef SPI_BRIGHTNESS_EN
    localparam logic BR_EN = 1'b1;
`else
    localparam logic BR_EN = 1'b0;
`endif
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] OFFSET  = 3'd2;
    localparam logic [2:0] BRIGHT  = 3'd3;
    localparam logic [2:0] COMMIT  = 3'd4;
    localparam logic [2:0] DISCARD = 3'd5;

    logic [SS_SYNC:0] ss_q;
    logic [2:0]       sclk_q;
    logic [1:0]       mosi_q;
    logic             ss_s, ss_end, sclk_rise, sclk_fall;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx, tx;
    logic             rx_vld, skip;
    logic [2:0]       state, st_nx;
    logic [CLW-1:0]   col;
    logic [NW-1:0]    chan;
    logic             dropped, locked, ready_q;
    logic             row_ok, is_load, is_off, is_br, is_cm, col_ok, col_end;

    // Synchronisers are left unreset so a reset mid-transaction cannot fake an ss edge.
    always_ff @(posedge clk) begin
        ss_q   <= {ss_q[SS_SYNC-1:0], ss};
        sclk_q <= {sclk_q[1:0], sclk};
        mosi_q <= {mosi_q[0], mosi};
    end

    assign ss_s      = ss_q[SS_SYNC-1];
    assign ss_end    = ss_q[SS_SYNC-1] & ~ss_q[SS_SYNC];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign miso      = tx[7];

    // Mode 0 byte receiver, MSB first; miso echoes the previous byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
            rx_vld  <= 1'b0;
            skip    <= 1'b1;
        end else begin
            rx_vld <= 1'b0;
            if (ss_s) begin
                bit_cnt <= '0;
                skip    <= 1'b0;
            end else if (sclk_rise) begin
                rx      <= {rx[6:0], mosi_q[1]};
                bit_cnt <= bit_cnt + 3'd1;
                rx_vld  <= (bit_cnt == 3'd7) && !skip;
                if (bit_cnt == 3'd7)
                    tx <= {rx[6:0], mosi_q[1]};
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                tx <= {tx[6:0], 1'b0};
            end
        end
    end

    assign row_ok  = 32'(rx[3:0]) < ROWS;
    assign is_load = (rx[7:4] == 4'hF) && row_ok;
    assign is_off  = (rx[7:4] == 4'hE) && row_ok;
    assign is_br   = BR_EN && (rx == 8'h20);
    assign is_cm   = rx == 8'h10;
    assign col_ok  = 32'(rx) < COLUMNS;
    assign col_end = 32'(col) >= COLUMNS;

    // State after the current byte, so a byte coinciding with the end edge still counts.
    always_comb begin
        st_nx = !rx_vld ? state :
                state == IDLE ? (is_load ? LOAD : is_off ? OFFSET : is_br ? BRIGHT : is_cm ? COMMIT : DISCARD) :
                state == OFFSET ? (col_ok ? LOAD : DISCARD) :
                state == BRIGHT ? DISCARD : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fb.wdata      <= '0;
            fb.wrow       <= '0;
            fb.wcol       <= '0;
            fb.wen        <= 1'b0;
            fb.loaded     <= 1'b0;
            fb.err        <= 1'b0;
            fb.brightness <= 8'hFF;
            locked        <= 1'b0;
            ready_q       <= 1'b0;
            col           <= '0;
            chan          <= '0;
            dropped       <= 1'b0;
        end else begin
            fb.wen    <= 1'b0;
            fb.loaded <= 1'b0;
            fb.err    <= 1'b0;
            ready_q   <= fb.ready;
            state     <= ss_end ? IDLE : st_nx;
            if (fb.ready && !ready_q)
                locked <= 1'b0;
            if (ss_end && st_nx == COMMIT && !locked) begin
                fb.loaded <= 1'b1;
                locked    <= 1'b1;
            end
            if (rx_vld && state == IDLE) begin
                fb.err  <= st_nx == DISCARD;
                col     <= '0;
                chan    <= '0;
                dropped <= 1'b0;
                if (is_load || is_off)
                    fb.wrow <= RW'(rx[3:0]);
            end
            if (rx_vld && state == OFFSET) begin
                fb.err <= !col_ok;
                col    <= CLW'(rx);
            end
            if (rx_vld && state == BRIGHT)
                fb.brightness <= BR_EN ? rx : 8'hFF;
            if (rx_vld && state == LOAD) begin
                if (col_end) begin
                    fb.err  <= !dropped;
                    dropped <= 1'b1;
                end else begin
                    fb.wdata <= (fb.wdata << 8) | W'(rx);
                    if (chan == NW'(N - 1)) begin
                        chan    <= '0;
                        fb.wen  <= !locked;
                        fb.wcol <= CW'(col);
                        col     <= col + CLW'(1);
                    end else begin
                        chan <= chan + NW'(1);
                    end
                end
            end
        end
    end
endmodule
